// File: rtl/bmp_pixel_writer.sv
// Purpose: writes the BMP pixel array (bottom-up rows, 24-bit BGR, 4-byte row padding)
//          for a cropped box of an RGB565 frame, starting at the byte after the BMP header.
// Latency: 5 cycles per pixel plus one cycle per pad byte; done rises the cycle after the last write.
// Backpressure: none; source reads return in a fixed 1 cycle and output writes always land.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start / done / err       run control; err reports an invalid box while done is high
//   xMin, xMax, yMin, yMax   inclusive crop box, latched on an accepted start
//   src_addr/src_rden        source frame read request; src_rddata returns one cycle later
//   addr/wren/wrdata         byte-per-word output memory write port ({8'h00, byte})
module bmp_pixel_writer #(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int HDR_BYTES = 54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic        err,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  output logic [23:0] src_addr,
  output logic        src_rden,
  input  logic [15:0] src_rddata,
  output logic [23:0] addr,
  output logic        wren,
  output logic [15:0] wrdata
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WR_B, WR_G, WR_R, PAD, DONE} state_t;

  state_t      state;
  logic [10:0] x, y;
  logic [10:0] x_min, x_max, y_min;
  logic [15:0] pix;
  logic [23:0] out_addr;
  logic [1:0]  pad_cnt;
  logic [1:0]  pad;
  logic        box_bad;

  // 3 bytes per pixel: row length 3w is padded to a multiple of 4 by w mod 4 bytes
  assign pad = 2'(x_max[1:0] - x_min[1:0] + 2'd1);

  assign box_bad = (xMin > xMax) || (yMin > yMax) ||
                   (24'(xMax) >= 24'(WIDTH)) || (24'(yMax) >= 24'(HEIGHT));

  function automatic logic [23:0] pix_addr(input logic [10:0] yy, input logic [10:0] xx);
    return 24'(yy) * 24'(WIDTH) + 24'(xx);
  endfunction

  // Channel widening by replicating the top bits into the new low bits
  function automatic logic [7:0] exp_b(input logic [15:0] d);
    return {d[4:0], d[4:2]};
  endfunction
  function automatic logic [7:0] exp_g(input logic [15:0] d);
    return {d[10:5], d[10:9]};
  endfunction
  function automatic logic [7:0] exp_r(input logic [15:0] d);
    return {d[15:11], d[15:13]};
  endfunction

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      wren     <= 1'b0;
      src_rden <= 1'b0;
      addr     <= '0;
      wrdata   <= '0;
      src_addr <= '0;
      x        <= '0;
      y        <= '0;
      x_min    <= '0;
      x_max    <= '0;
      y_min    <= '0;
      pix      <= '0;
      out_addr <= '0;
      pad_cnt  <= '0;
    end else begin
      wren     <= 1'b0;
      src_rden <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_min <= xMin;
            x_max <= xMax;
            y_min <= yMin;
            if (box_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              done     <= 1'b0;
              err      <= 1'b0;
              x        <= xMin;
              y        <= yMax;
              out_addr <= 24'(HDR_BYTES);
              src_rden <= 1'b1;
              src_addr <= pix_addr(yMax, xMin);
              state    <= READ;
            end
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          pix      <= src_rddata;
          wren     <= 1'b1;
          addr     <= out_addr;
          wrdata   <= {8'h00, exp_b(src_rddata)};
          out_addr <= out_addr + 24'd1;
          state    <= WR_B;
        end
        WR_B: begin
          wren     <= 1'b1;
          addr     <= out_addr;
          wrdata   <= {8'h00, exp_g(pix)};
          out_addr <= out_addr + 24'd1;
          state    <= WR_G;
        end
        WR_G: begin
          wren     <= 1'b1;
          addr     <= out_addr;
          wrdata   <= {8'h00, exp_r(pix)};
          out_addr <= out_addr + 24'd1;
          state    <= WR_R;
        end
        WR_R: begin
          if (x < x_max) begin
            x        <= x + 11'd1;
            src_rden <= 1'b1;
            src_addr <= pix_addr(y, x + 11'd1);
            state    <= READ;
          end else if (pad != 2'd0) begin
            wren     <= 1'b1;
            addr     <= out_addr;
            wrdata   <= 16'h0000;
            out_addr <= out_addr + 24'd1;
            pad_cnt  <= pad - 2'd1;   // bytes still owed after this one
            state    <= PAD;
          end else if (y > y_min) begin
            y        <= y - 11'd1;
            x        <= x_min;
            src_rden <= 1'b1;
            src_addr <= pix_addr(y - 11'd1, x_min);
            state    <= READ;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        PAD: begin
          if (pad_cnt != 2'd0) begin
            wren     <= 1'b1;
            addr     <= out_addr;
            wrdata   <= 16'h0000;
            out_addr <= out_addr + 24'd1;
            pad_cnt  <= pad_cnt - 2'd1;
          end else if (y > y_min) begin
            y        <= y - 11'd1;
            x        <= x_min;
            src_rden <= 1'b1;
            src_addr <= pix_addr(y - 11'd1, x_min);
            state    <= READ;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
